// File: rtl/memaccess_ctrl.sv
// Data-memory access sequencer: direct or pointer-indirect load/store with registered outputs.
// Optional ack-wait timeout is compiled in with `define MEMACCESS_CTRL_TIMEOUT_EN.
module memaccess_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  mem_state,
    input  logic        m_control,
    input  logic [15:0] m_addr,
    input  logic [15:0] m_data,
    input  logic [15:0] dmem_dout,
    input  logic        dmem_ack,
    output logic        dmem_req,
    output logic        dmem_rd,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_din,
    output logic [15:0] memout,
    output logic        done,
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic [2:0] {IDLE, PTR, RD, WR, FIN} state_t;

    state_t      state_q, state_d;
    logic        is_wr_q, is_wr_d;
    logic        dmem_req_q, dmem_req_d;
    logic        dmem_rd_q, dmem_rd_d;
    logic [15:0] dmem_addr_q, dmem_addr_d;
    logic [15:0] dmem_din_q, dmem_din_d;
    logic [15:0] memout_q, memout_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic        accept;
    logic        tmo_hit;

    assign accept = (state_q == IDLE) && start;

`ifdef MEMACCESS_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          timeout_err_q, timeout_err_d;

    // Counts only cycles where a request is outstanding and unanswered.
    always_comb begin
        tmo_cnt_d     = '0;
        tmo_hit       = 1'b0;
        timeout_err_d = timeout_err_q;
        if (dmem_req_q && !dmem_ack) begin
            if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                tmo_hit = 1'b1;
            end else begin
                tmo_cnt_d = tmo_cnt_q + TW'(1);
            end
        end
        if (accept) begin
            timeout_err_d = 1'b0;
        end else if (tmo_hit) begin
            timeout_err_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tmo_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            tmo_cnt_q     <= tmo_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        is_wr_d     = is_wr_q;
        dmem_req_d  = dmem_req_q;
        dmem_rd_d   = dmem_rd_q;
        dmem_addr_d = dmem_addr_q;
        dmem_din_d  = dmem_din_q;
        memout_d    = memout_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    dmem_addr_d = m_addr;
                    dmem_din_d  = m_data;
                    is_wr_d     = (mem_state == 2'b10);
                    if (mem_state == 2'b11) begin
                        state_d = FIN;
                    end else if (m_control) begin
                        state_d    = PTR;
                        dmem_req_d = 1'b1;
                        dmem_rd_d  = 1'b1;
                    end else if (!mem_state[1]) begin
                        state_d    = RD;
                        dmem_req_d = 1'b1;
                        dmem_rd_d  = 1'b1;
                    end else begin
                        state_d    = WR;
                        dmem_req_d = 1'b1;
                        dmem_rd_d  = 1'b0;
                    end
                end
            end
            PTR, RD, WR: begin
                if (dmem_req_q) begin
                    if (dmem_ack) begin
                        dmem_req_d = 1'b0;
                        if (state_q == PTR) begin
                            dmem_addr_d = dmem_dout;
                            dmem_rd_d   = !is_wr_q;
                            state_d     = is_wr_q ? WR : RD;
                        end else begin
                            if (state_q == RD) begin
                                memout_d = dmem_dout;
                            end
                            state_d = FIN;
                        end
                    end else if (tmo_hit) begin
                        dmem_req_d = 1'b0;
                        state_d    = FIN;
                    end
                end else begin
                    // Idle request cycle after the pointer fetch; issue the data phase now.
                    dmem_req_d = 1'b1;
                end
            end
            FIN: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d    = IDLE;
                dmem_req_d = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            is_wr_q     <= 1'b0;
            dmem_req_q  <= 1'b0;
            dmem_rd_q   <= 1'b0;
            dmem_addr_q <= '0;
            dmem_din_q  <= '0;
            memout_q    <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            is_wr_q     <= is_wr_d;
            dmem_req_q  <= dmem_req_d;
            dmem_rd_q   <= dmem_rd_d;
            dmem_addr_q <= dmem_addr_d;
            dmem_din_q  <= dmem_din_d;
            memout_q    <= memout_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign dmem_req  = dmem_req_q;
    assign dmem_rd   = dmem_rd_q;
    assign dmem_addr = dmem_addr_q;
    assign dmem_din  = dmem_din_q;
    assign memout    = memout_q;
    assign done      = done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_memaccess_ctrl.sv
// Randomized self-checking bench for memaccess_ctrl against a transaction-level memory model.
module tb_memaccess_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  mem_state;
    logic        m_control;
    logic [15:0] m_addr;
    logic [15:0] m_data;
    logic [15:0] dmem_dout;
    logic        dmem_ack;
    logic        dmem_req;
    logic        dmem_rd;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_din;
    logic [15:0] memout;
    logic        done;
    logic        busy;
    logic        timeout_err;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] model_memout;

    memaccess_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clock(clock), .reset(reset), .start(start), .mem_state(mem_state),
        .m_control(m_control), .m_addr(m_addr), .m_data(m_data),
        .dmem_dout(dmem_dout), .dmem_ack(dmem_ack), .dmem_req(dmem_req),
        .dmem_rd(dmem_rd), .dmem_addr(dmem_addr), .dmem_din(dmem_din),
        .memout(memout), .done(done), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One transaction: the bench plays the memory, acking phase p after ph_w[p] wait cycles.
    task automatic applyStimulus(input logic [1:0] ms, input logic ctl,
                                 input logic [15:0] addr, input logic [15:0] data,
                                 input logic [15:0] ptr_val, input logic [15:0] rd_val,
                                 input int w0, input int w1, input bit poke_start);
        int          nph;
        int          exp_lat;
        logic        ph_rd   [2];
        logic [15:0] ph_addr [2];
        int          ph_w    [2];
        int          ph;
        int          req_cnt;
        int          done_c;
        bit          acked;
        logic        acc_rd;
        logic [15:0] acc_addr;

        acc_rd   = (ms != 2'b10);
        acc_addr = ctl ? ptr_val : addr;
        if (ms == 2'b11) begin
            nph = 0; exp_lat = 2;
        end else if (ctl) begin
            nph = 2; exp_lat = 5 + w0 + w1;
            ph_rd[0] = 1'b1;   ph_addr[0] = addr;     ph_w[0] = w0;
            ph_rd[1] = acc_rd; ph_addr[1] = acc_addr; ph_w[1] = w1;
        end else begin
            nph = 1; exp_lat = 3 + w0;
            ph_rd[0] = acc_rd; ph_addr[0] = acc_addr; ph_w[0] = w0;
        end

        @(negedge clock);
        mem_state = ms; m_control = ctl; m_addr = addr; m_data = data;
        start = 1'b1; dmem_ack = 1'b0;
        ph = 0; req_cnt = 0; done_c = -1; acked = 1'b0;

        for (int c = 1; c <= 80; c++) begin
            @(negedge clock);
            if (acked) begin
                checkOutput("req_drop_after_ack", dmem_req, 1'b0);
                acked = 1'b0;
                ph++;
                req_cnt = 0;
            end else if (ph >= nph) begin
                checkOutput("req_when_none_due", dmem_req, 1'b0);
            end else if (dmem_req) begin
                checkOutput("req_rd", dmem_rd, ph_rd[ph]);
                checkOutput("req_addr", dmem_addr, ph_addr[ph]);
                if (!ph_rd[ph]) checkOutput("req_din", dmem_din, data);
            end
            if (c == 1) checkOutput("busy_after_start", busy, 1'b1);
            if (done) begin
                done_c = c;
                start = 1'b0;
                dmem_ack = 1'b0;
                break;
            end
            start = poke_start && ($urandom_range(0, 2) == 0);
            mem_state = 2'($urandom); m_control = 1'($urandom);
            m_addr = 16'($urandom); m_data = 16'($urandom);
            if (dmem_req && ph < nph && !acked) begin
                if (req_cnt == ph_w[ph]) begin
                    dmem_ack  = 1'b1;
                    dmem_dout = (ctl && ph == 0) ? ptr_val : rd_val;
                    acked     = 1'b1;
                end else begin
                    dmem_ack  = 1'b0;
                    dmem_dout = 16'($urandom);
                end
                req_cnt++;
            end else begin
                dmem_ack  = 1'($urandom);
                dmem_dout = 16'($urandom);
            end
        end

        if (ms == 2'b00 || ms == 2'b01) model_memout = rd_val;
        checkOutput("done_latency", 32'(done_c), 32'(exp_lat));
        checkOutput("phases_completed", 32'(ph), 32'(nph));
        checkOutput("memout", memout, model_memout);
        checkOutput("busy_at_done", busy, 1'b0);
        checkOutput("timeout_err_clear", timeout_err, 1'b0);
        @(negedge clock);
        checkOutput("done_single_pulse", done, 1'b0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_req"}, dmem_req, 1'b0);
        checkOutput({tag, "_rd"}, dmem_rd, 1'b0);
        checkOutput({tag, "_addr"}, dmem_addr, 16'h0);
        checkOutput({tag, "_din"}, dmem_din, 16'h0);
        checkOutput({tag, "_memout"}, memout, 16'h0);
        checkOutput({tag, "_done"}, done, 1'b0);
        checkOutput({tag, "_busy"}, busy, 1'b0);
        checkOutput({tag, "_tmo"}, timeout_err, 1'b0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mem_state = 2'b00; m_control = 1'b0;
        m_addr = 16'h0; m_data = 16'h0; dmem_dout = 16'h0; dmem_ack = 1'b0;
        model_memout = 16'h0;
        repeat (2) @(negedge clock);
        checkResetState("reset");
        reset = 1'b0;

        applyStimulus(2'b00, 1'b0, 16'h3010, 16'h0000, 16'h0000, 16'hBEEF, 0, 0, 1'b0);
        applyStimulus(2'b10, 1'b1, 16'h3000, 16'h1234, 16'h4000, 16'h0000, 0, 0, 1'b0);
        applyStimulus(2'b11, 1'b0, 16'h5555, 16'hAAAA, 16'h0000, 16'h0000, 0, 0, 1'b0);
        applyStimulus(2'b01, 1'b0, 16'h2222, 16'h0000, 16'h0000, 16'h7E57, 4, 0, 1'b1);
        applyStimulus(2'b10, 1'b0, 16'h0F0F, 16'hCAFE, 16'h0000, 16'h0000, 2, 0, 1'b1);

        // Reset in the middle of a pointer fetch, then a stray ack.
        @(negedge clock);
        mem_state = 2'b00; m_control = 1'b1; m_addr = 16'h3000; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        checkOutput("ptr_req_before_reset", dmem_req, 1'b1);
        #2 reset = 1'b1;
        #1 checkResetState("async_reset");
        model_memout = 16'h0;
        @(negedge clock);
        reset = 1'b0; dmem_ack = 1'b1; dmem_dout = 16'h9999;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            checkOutput("post_reset_done", done, 1'b0);
            checkOutput("post_reset_busy", busy, 1'b0);
            checkOutput("post_reset_req", dmem_req, 1'b0);
        end
        dmem_ack = 1'b0;

        // Request that is never acknowledged.
        @(negedge clock);
        mem_state = 2'b00; m_control = 1'b0; m_addr = 16'h1357; start = 1'b1;
`ifdef MEMACCESS_CTRL_TIMEOUT_EN
        begin
            int req_cycles;
            int done_c;
            req_cycles = 0; done_c = -1;
            for (int c = 1; c <= 40; c++) begin
                @(negedge clock);
                start = 1'b0;
                if (dmem_req) req_cycles++;
                if (done) begin
                    done_c = c;
                    break;
                end
            end
            checkOutput("tmo_req_cycles", 32'(req_cycles), 32'd16);
            checkOutput("tmo_done_cycle", 32'(done_c), 32'd18);
            checkOutput("tmo_err_set", timeout_err, 1'b1);
            checkOutput("tmo_memout_kept", memout, model_memout);
        end
`else
        for (int c = 1; c <= 30; c++) begin
            @(negedge clock);
            start = 1'b0;
            checkOutput("noack_req_held", dmem_req, 1'b1);
            checkOutput("noack_addr_stable", dmem_addr, 16'h1357);
            checkOutput("noack_no_done", done, 1'b0);
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        model_memout = 16'h0;
`endif

        for (int n = 0; n < 40; n++) begin
            logic [1:0] ms;
            ms = 2'($urandom);
            applyStimulus(ms, 1'($urandom), 16'($urandom), 16'($urandom),
                          16'($urandom), 16'($urandom),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
